me_mem_responder: RTL and testbench

ME_MEM_RESPONDER -- requirements
Module: me_mem_responder

---
 rtl/me_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_me_mem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/me_mem_responder.sv
// me_mem_responder
// Holds the 16x16 reference block R and the 31x31 search window S for a
// motion-estimation core. It loads both memories while idle, launches a run
// on go, times the run and captures the core's result on completion.
//
// Optional build macro:
//   ME_MEM_REG_READ_EN -- when defined, the R/S1/S2 read ports are registered
//                         (1-cycle latency, cleared by reset). When undefined,
//                         the read ports are combinational from the address.
//
// FSM states:
//   IDLE | loads accepted, waiting for go
//   RUN  | core running, start high, run_cycles counting
//   DONE | result captured, res_valid high for this one cycle
module me_mem_responder (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [9:0]        ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              go,
  output logic              start,
  input  logic [7:0]        AddressR,
  input  logic [9:0]        AddressS1,
  input  logic [9:0]        AddressS2,
  output logic [7:0]        R,
  output logic [7:0]        S1,
  output logic [7:0]        S2,
  input  logic              completed,
  input  logic [7:0]        BestDist,
  input  logic signed [3:0] motionX,
  input  logic signed [3:0] motionY,
  output logic              res_valid,
  output logic [7:0]        res_dist,
  output logic [3:0]        res_mx,
  output logic [3:0]        res_my,
  output logic [15:0]       run_cycles,
  output logic              ld_err
);

  localparam logic [9:0] S_LAST = 10'd960;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        start_q;
  logic        res_valid_q;
  logic [7:0]  res_dist_q;
  logic [3:0]  res_mx_q;
  logic [3:0]  res_my_q;
  logic [15:0] run_cycles_q;
  logic        ld_err_q;

  logic [7:0]  r_mem [0:255];
  logic [7:0]  s_mem [0:960];

  logic        in_idle;
  logic        wr_r;
  logic        wr_s;
  logic        ld_bad;
  logic [7:0]  r_rd_d;
  logic [7:0]  s1_rd_d;
  logic [7:0]  s2_rd_d;

  // Load decode: only IDLE accepts loads; out-of-range addresses are dropped
  // and flagged instead of aliasing into the arrays.
  always_comb begin
    in_idle = (state_q == ST_IDLE);
    wr_r    = in_idle && ld_valid && !ld_sel && (ld_addr[9:8] == 2'b00);
    wr_s    = in_idle && ld_valid && ld_sel && (ld_addr <= S_LAST);
    ld_bad  = in_idle && ld_valid &&
              (ld_sel ? (ld_addr > S_LAST) : (ld_addr[9:8] != 2'b00));
  end

  // Memory arrays are deliberately not reset so loaded data survives an abort.
  always_ff @(posedge clock) begin
    if (wr_r) r_mem[ld_addr[7:0]] <= ld_data;
    if (wr_s) s_mem[ld_addr]      <= ld_data;
  end

  // Raw read data; S addresses past the window read as zero.
  always_comb begin
    r_rd_d  = r_mem[AddressR];
    s1_rd_d = (AddressS1 > S_LAST) ? 8'h00 : s_mem[AddressS1];
    s2_rd_d = (AddressS2 > S_LAST) ? 8'h00 : s_mem[AddressS2];
  end

`ifdef ME_MEM_REG_READ_EN
  logic [7:0] r_q;
  logic [7:0] s1_q;
  logic [7:0] s2_q;

  // Registered read ports: data for the address sampled at an edge appears after it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q  <= 8'h00;
      s1_q <= 8'h00;
      s2_q <= 8'h00;
    end else begin
      r_q  <= r_rd_d;
      s1_q <= s1_rd_d;
      s2_q <= s2_rd_d;
    end
  end

  assign R  = r_q;
  assign S1 = s1_q;
  assign S2 = s2_q;
`else
  assign R  = r_rd_d;
  assign S1 = s1_rd_d;
  assign S2 = s2_rd_d;
`endif

  // Run sequencer with registered start/result outputs and the sticky load error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_dist_q   <= 8'h00;
      res_mx_q     <= 4'h0;
      res_my_q     <= 4'h0;
      run_cycles_q <= 16'h0000;
      ld_err_q     <= 1'b0;
    end else begin
      if (ld_bad) ld_err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          res_valid_q <= 1'b0;
          if (go) begin
            state_q      <= ST_RUN;
            start_q      <= 1'b1;
            run_cycles_q <= 16'h0000;
          end
        end
        ST_RUN: begin
          if (run_cycles_q != 16'hFFFF) run_cycles_q <= run_cycles_q + 16'd1;
          if (completed) begin
            state_q     <= ST_DONE;
            start_q     <= 1'b0;
            res_valid_q <= 1'b1;
            res_dist_q  <= BestDist;
            res_mx_q    <= motionX;
            res_my_q    <= motionY;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          res_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          start_q     <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready   = in_idle;
  assign start      = start_q;
  assign res_valid  = res_valid_q;
  assign res_dist   = res_dist_q;
  assign res_mx     = res_mx_q;
  assign res_my     = res_my_q;
  assign run_cycles = run_cycles_q;
  assign ld_err     = ld_err_q;

endmodule

// File: tb/tb_me_mem_responder.sv
// Testbench for me_mem_responder: directed sequence with randomized loads and
// reads, checked against array models of R and S kept in the bench.
module tb_me_mem_responder;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_sel;
  logic [9:0]        ld_addr;
  logic [7:0]        ld_data;
  logic              go;
  logic              start;
  logic [7:0]        AddressR;
  logic [9:0]        AddressS1;
  logic [9:0]        AddressS2;
  logic [7:0]        R;
  logic [7:0]        S1;
  logic [7:0]        S2;
  logic              completed;
  logic [7:0]        BestDist;
  logic signed [3:0] motionX;
  logic signed [3:0] motionY;
  logic              res_valid;
  logic [7:0]        res_dist;
  logic [3:0]        res_mx;
  logic [3:0]        res_my;
  logic [15:0]       run_cycles;
  logic              ld_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_r [0:255];
  logic [7:0] ref_s [0:960];
  logic       ref_err;

  me_mem_responder dut (
    .clock(clock), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .go(go), .start(start),
    .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .R(R), .S1(S1), .S2(S2),
    .completed(completed), .BestDist(BestDist),
    .motionX(motionX), .motionY(motionY),
    .res_valid(res_valid), .res_dist(res_dist), .res_mx(res_mx), .res_my(res_my),
    .run_cycles(run_cycles), .ld_err(ld_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] s_exp(input logic [9:0] a);
    if (a > 10'd960) return 8'h00;
    return ref_s[a];
  endfunction

  // One load cycle; the model applies the write/error rule only when idle.
  task automatic do_load(input logic sel, input logic [9:0] addr, input logic [7:0] data,
                         input bit idle);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    tick();
    ld_valid = 1'b0;
    if (idle) begin
      if (!sel) begin
        if (addr[9:8] == 2'b00) ref_r[addr[7:0]] = data;
        else ref_err = 1'b1;
      end else begin
        if (addr <= 10'd960) ref_s[addr] = data;
        else ref_err = 1'b1;
      end
    end
  endtask

  // Set read addresses, let an edge pass (valid for either read build), compare.
  task automatic rd_check(input string tag, input logic [7:0] ar,
                          input logic [9:0] a1, input logic [9:0] a2);
    AddressR = ar; AddressS1 = a1; AddressS2 = a2;
    tick();
    chk({tag, "_R"},  {24'h0, R},  {24'h0, ref_r[ar]});
    chk({tag, "_S1"}, {24'h0, S1}, {24'h0, s_exp(a1)});
    chk({tag, "_S2"}, {24'h0, S2}, {24'h0, s_exp(a2)});
  endtask

  task automatic rand_reads(input string tag, input int n);
    for (int k = 0; k < n; k++)
      rd_check(tag, 8'($urandom_range(0, 255)), 10'($urandom_range(0, 1023)),
               10'($urandom_range(0, 1023)));
  endtask

  initial begin
    logic [7:0] old_r;
    logic [7:0] ar_a;
    logic [7:0] ar_b;
    reset_n = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    go = 1'b0; AddressR = '0; AddressS1 = '0; AddressS2 = '0;
    completed = 1'b0; BestDist = '0; motionX = '0; motionY = '0;
    ref_err = 1'b0;

    // Reset state
    #3;
    chk("rst_start", {31'h0, start}, 32'h0);
    chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_res_dist", {24'h0, res_dist}, 32'h0);
    chk("rst_res_mx", {28'h0, res_mx}, 32'h0);
    chk("rst_res_my", {28'h0, res_my}, 32'h0);
    chk("rst_run_cycles", {16'h0, run_cycles}, 32'h0);
    chk("rst_ld_err", {31'h0, ld_err}, 32'h0);
    chk("rst_ld_ready", {31'h0, ld_ready}, 32'h1);
`ifdef ME_MEM_REG_READ_EN
    chk("rst_R", {24'h0, R}, 32'h0);
    chk("rst_S1", {24'h0, S1}, 32'h0);
`endif
    tick();
    reset_n = 1'b1;
    tick();

    // Full fill: R[i] = i, S[j] = j[7:0]
    for (int i = 0; i < 256; i++) do_load(1'b0, 10'(i), 8'(i), 1'b1);
    for (int j = 0; j < 961; j++) do_load(1'b1, 10'(j), 8'(j), 1'b1);
    chk("fill_ld_err", {31'h0, ld_err}, 32'h0);
    AddressR = 8'h37; AddressS1 = 10'd300; AddressS2 = 10'd0;
    tick();
    chk("fill_R37", {24'h0, R}, 32'h37);
    chk("fill_S300", {24'h0, S1}, 32'h2C);

    // Out-of-range loads
    do_load(1'b1, 10'd961, 8'hAA, 1'b1);
    do_load(1'b0, 10'h100, 8'hBB, 1'b1);
    chk("oor_ld_err", {31'h0, ld_err}, 32'h1);
    rd_check("oor", 8'h00, 10'd960, 10'd961);
    chk("oor_S960", {24'h0, S1}, 32'hC0);
    chk("oor_R0", {24'h0, R}, 32'h00);
    chk("oor_S2_961", {24'h0, S2}, 32'h00);

    // Random loads (incl. out-of-range) then random reads
    for (int k = 0; k < 200; k++)
      do_load(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 8'($urandom), 1'b1);
    chk("rnd_ld_err", {31'h0, ld_err}, {31'h0, ref_err});
    rand_reads("rnd", 40);

    // Run: go together with a load that must still land
    go = 1'b1;
    do_load(1'b0, 10'd5, 8'h77, 1'b1);
    go = 1'b0;
    chk("run_start", {31'h0, start}, 32'h1);
    chk("run_ld_ready", {31'h0, ld_ready}, 32'h0);
    chk("run_cycles0", {16'h0, run_cycles}, 32'h0);
    // Loads during RUN are dropped
    for (int k = 0; k < 20; k++) begin
      do_load(1'b0, 10'd6, 8'hFF, 1'b0);
      chk("run_ld_ready_hold", {31'h0, ld_ready}, 32'h0);
    end
    for (int k = 0; k < 979; k++) tick();
    chk("run_start_hold", {31'h0, start}, 32'h1);
    chk("run_no_res", {31'h0, res_valid}, 32'h0);
    completed = 1'b1; BestDist = 8'h12; motionX = -4'sd3; motionY = 4'sd7;
    tick();
    chk("done_res_valid", {31'h0, res_valid}, 32'h1);
    chk("done_res_dist", {24'h0, res_dist}, 32'h12);
    chk("done_res_mx", {28'h0, res_mx}, 32'hD);
    chk("done_res_my", {28'h0, res_my}, 32'h7);
    chk("done_start", {31'h0, start}, 32'h0);
    chk("done_run_cycles_range",
        {31'h0, (run_cycles >= 16'd998) && (run_cycles <= 16'd1002)}, 32'h1);
    // go and completed in DONE and afterwards must be ignored
    go = 1'b1; BestDist = 8'h55; motionX = 4'sd1; motionY = 4'sd1;
    tick();
    go = 1'b0;
    chk("post_res_valid", {31'h0, res_valid}, 32'h0);
    chk("post_start", {31'h0, start}, 32'h0);
    chk("post_ld_ready", {31'h0, ld_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_res_valid", {31'h0, res_valid}, 32'h0);
      chk("idle_start", {31'h0, start}, 32'h0);
    end
    completed = 1'b0;
    chk("hold_res_dist", {24'h0, res_dist}, 32'h12);
    chk("hold_res_mx", {28'h0, res_mx}, 32'hD);
    chk("hold_run_cycles_range",
        {31'h0, (run_cycles >= 16'd998) && (run_cycles <= 16'd1002)}, 32'h1);
    rd_check("afterrun", 8'd5, 10'd1, 10'd2);
    chk("afterrun_R5", {24'h0, R}, 32'h77);
    rd_check("afterrun6", 8'd6, 10'd3, 10'd4);

    // Reset mid-RUN aborts with no result strobe
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_start_pre", {31'h0, start}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_start", {31'h0, start}, 32'h0);
    chk("mid_rst_ld_ready", {31'h0, ld_ready}, 32'h1);
    chk("mid_rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("mid_rst_run_cycles", {16'h0, run_cycles}, 32'h0);
    chk("mid_rst_ld_err", {31'h0, ld_err}, 32'h0);
    chk("mid_rst_res_dist", {24'h0, res_dist}, 32'h0);
    ref_err = 1'b0;
    tick();
    reset_n = 1'b1;
    completed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_res_valid", {31'h0, res_valid}, 32'h0);
      chk("abort_start", {31'h0, start}, 32'h0);
    end
    completed = 1'b0;
    rand_reads("keep", 30);
    for (int k = 0; k < 60; k++)
      do_load(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 8'($urandom), 1'b1);
    chk("rnd2_ld_err", {31'h0, ld_err}, {31'h0, ref_err});
    rand_reads("rnd2", 20);

    // Read latency: address change just after an edge
    ar_a = 8'h10; ar_b = 8'h20;
    ref_r[ar_a] = 8'h5A; ref_r[ar_b] = 8'hA5;
    do_load(1'b0, {2'b00, ar_a}, 8'h5A, 1'b1);
    do_load(1'b0, {2'b00, ar_b}, 8'hA5, 1'b1);
    AddressR = ar_a;
    tick();
    old_r = ref_r[ar_a];
    AddressR = ar_b;
    #1;
`ifdef ME_MEM_REG_READ_EN
    chk("lat_before_edge", {24'h0, R}, {24'h0, old_r});
    tick();
    chk("lat_after_edge", {24'h0, R}, {24'h0, ref_r[ar_b]});
`else
    chk("lat_same_cycle", {24'h0, R}, {24'h0, ref_r[ar_b]});
    tick();
    chk("lat_after_edge", {24'h0, R}, {24'h0, ref_r[ar_b]});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
